// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared definitions for the sequential restoring divider.
//   - DIV_WIDTH   : default operand/result width
//   - state_e     : controller state encoding (IDLE, RUN, FIX)
//   - DZ_QUOTIENT : quotient returned for a division by zero (all ones)
package seq_div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Ports:
//   i_rem  [WIDTH] partial remainder before the shift (always < i_dmag)
//   i_bit  [1]     next dividend bit shifted into the remainder
//   i_dmag [WIDTH] divisor magnitude
//   o_rem  [WIDTH] partial remainder after the step
//   o_qbit [1]     quotient bit produced by this step
module div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dmag,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;

  // The shifted remainder needs WIDTH+1 bits; the trial subtraction is
  // non-negative exactly when the wide value is >= the divisor. When it is,
  // the difference is < divisor and fits in WIDTH bits, so the low-order
  // subtraction alone gives the new remainder.
  assign w_shifted = {i_rem, i_bit};
  assign o_qbit    = (w_shifted >= {1'b0, i_dmag});
  assign w_diff    = w_shifted[WIDTH-1:0] - i_dmag;
  assign o_rem     = o_qbit ? w_diff : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for MIPS DIV/DIVU.
// One quotient bit per clock; 33 edges from accepted start to done,
// 1 edge for a zero divisor.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   start                request (sampled in IDLE only)
//   is_signed            1 = DIV (two's complement), 0 = DIVU
//   dividend, divisor    operands, sampled with start
//   busy                 high from the accepted start until done
//   done                 one-cycle pulse, results valid from this cycle
//   quotient, remainder  registered results (LO / HI)
//   div_zero             registered divide-by-zero indication
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DZ_Q     = WIDTH'(DZ_QUOTIENT);

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;      // dividend magnitude, shifted into quotient
  logic [WIDTH-1:0] r_dmag;
  logic [WIDTH-1:0] r_dividend; // raw dividend, returned on divide by zero
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_zero;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_quo[WIDTH-1]),
    .i_dmag (r_dmag),
    .o_rem  (w_step_rem),
    .o_qbit (w_step_qbit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (divisor == {WIDTH{1'b0}}) ? ST_FIX : ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_next_state = ST_FIX;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem       <= {WIDTH{1'b0}};
      r_quo       <= {WIDTH{1'b0}};
      r_dmag      <= {WIDTH{1'b0}};
      r_dividend  <= {WIDTH{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dz        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= {WIDTH{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
      r_div_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_dividend <= dividend;
            r_sign_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_sign_r   <= is_signed & dividend[WIDTH-1];
            r_quo      <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            r_dmag     <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
            r_rem      <= {WIDTH{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_dz       <= (divisor == {WIDTH{1'b0}});
            r_busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          r_rem <= w_step_rem;
          r_quo <= {r_quo[WIDTH-2:0], w_step_qbit};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_dz) begin
            r_quotient  <= DZ_Q;
            r_remainder <= r_dividend;
            r_div_zero  <= 1'b1;
          end else begin
            // Magnitude result with signs restored: truncation toward zero,
            // remainder takes the sign of the dividend.
            r_quotient  <= r_sign_q ? -r_quo : r_quo;
            r_remainder <= r_sign_r ? -r_rem : r_rem;
            r_div_zero  <= 1'b0;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against an
// arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU results computed with plain integer arithmetic.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
    int sa;
    int sb;
    dz = 1'b0;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  // Issue one divide and check busy, latency, results and the done pulse width.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    int          lat;
    ref_div(a, b, sgn, eq, er, edz);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; is_signed = sgn;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), (b == 32'd0) ? 32'd1 : 32'd33);
    check({tag, ".q"}, quotient, eq);
    check({tag, ".r"}, remainder, er);
    check({tag, ".dz"}, 32'(div_zero), 32'(edz));
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          lat;
    int          extra_done;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.q", quotient, 32'd0);
    check("rst.r", remainder, 32'd0);
    check("rst.dz", 32'(div_zero), 32'd0);
    reset = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, "u100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s-7_2");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, "u-7_2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "u_max_1");
    run_div(32'd5, 32'd0, 1'b1, "s5_0");
    run_div(32'd5, 32'd0, 1'b0, "u5_0");
    run_div(32'd9, 32'd3, 1'b0, "u9_3");
    run_div(32'hFFFF_FFF6, 32'd0, 1'b1, "s-10_0");

    // start during RUN is ignored and produces no second done
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 10;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ign.lat", 32'(lat), 32'd33);
    check("ign.q", quotient, 32'd14);
    check("ign.r", remainder, 32'd2);
    extra_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    check("ign.extra_done", 32'(extra_done), 32'd0);

    // reset in the middle of RUN discards the operation
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mrst.busy", 32'(busy), 32'd0);
    check("mrst.done", 32'(done), 32'd0);
    check("mrst.dz", 32'(div_zero), 32'd0);
    check("mrst.q", quotient, 32'd0);
    check("mrst.r", remainder, 32'd0);
    extra_done = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    check("mrst.no_done", 32'(extra_done), 32'd0);
    run_div(32'd20, 32'd6, 1'b0, "u20_6");

    // randomized operands across both modes and divisor classes
    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      sgn = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(0, 15);
        2:       b = 32'hFFFF_FFFF - $urandom_range(0, 7);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(a, b, sgn, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
